// File: rtl/snake_step_scheduler.sv
// Step scheduler for the snake game core: paces movement from the selected period,
// holds each step request until acknowledged and runs the IDLE/RUN/PAUSE/DEAD flow.
module snake_step_scheduler #(
  parameter int PERIOD_W   = 41,
  parameter int MIN_PERIOD = 1_000_000,
  parameter int COUNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pause,
  input  logic                collide,
  input  logic [PERIOD_W-1:0] period,
  input  logic                step_ack,
  output logic                step_req,
  output logic [1:0]          state,
  output logic [COUNT_W-1:0]  step_count,
  output logic                overrun
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DEAD  = 2'b11
  } state_e;

  localparam logic [PERIOD_W-1:0] CNT_ZERO = {PERIOD_W{1'b0}};
  localparam logic [PERIOD_W-1:0] CNT_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0]  STEP_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0]  STEP_MAX = {COUNT_W{1'b1}};
  // A floor of zero would make p_eff-1 wrap, so the floor is never below one cycle.
  localparam logic [PERIOD_W-1:0] MIN_P    =
    (MIN_PERIOD > 0) ? PERIOD_W'(MIN_PERIOD) : CNT_ONE;

  state_e               state_r, state_s;
  logic [PERIOD_W-1:0]  cnt_r, cnt_s;
  logic                 req_r, req_s;
  logic [COUNT_W-1:0]   count_r, count_s;
  logic                 ovr_r, ovr_s;

  logic [PERIOD_W-1:0]  p_eff_s;
  logic [PERIOD_W-1:0]  last_s;
  logic                 expire_s;
  logic                 req_kept_s;
  logic [COUNT_W-1:0]   count_inc_s;

  // Live effective period and the expiry condition against the running count.
  always_comb begin
    p_eff_s     = (period < MIN_P) ? MIN_P : period;
    last_s      = p_eff_s - CNT_ONE;
    expire_s    = (cnt_r >= last_s);
    req_kept_s  = req_r & ~step_ack;
    count_inc_s = (count_r == STEP_MAX) ? count_r : (count_r + STEP_ONE);
  end

  // Game-flow next state, step handshake and score bookkeeping.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    req_s   = req_r;
    count_s = count_r;
    ovr_s   = ovr_r;
    case (state_r)
      ST_IDLE, ST_DEAD: begin
        cnt_s = CNT_ZERO;
        req_s = 1'b0;
        if (start) begin
          state_s = ST_RUN;
          count_s = {COUNT_W{1'b0}};
          ovr_s   = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (collide) begin
          state_s = ST_DEAD;
          cnt_s   = CNT_ZERO;
          req_s   = 1'b0;
        end else if (pause) begin
          // Counter freezes on the pause edge itself, so resume loses no phase.
          state_s = ST_PAUSE;
          req_s   = req_kept_s;
        end else if (expire_s) begin
          cnt_s = CNT_ZERO;
          if (req_kept_s) begin
            req_s = 1'b1;
            ovr_s = 1'b1;
          end else begin
            req_s   = 1'b1;
            count_s = count_inc_s;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
          req_s = req_kept_s;
        end
      end
      ST_PAUSE: begin
        if (collide) begin
          state_s = ST_DEAD;
          cnt_s   = CNT_ZERO;
          req_s   = 1'b0;
        end else if (pause) begin
          state_s = ST_RUN;
          req_s   = req_kept_s;
        end else begin
          state_s = ST_PAUSE;
          req_s   = req_kept_s;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        req_s   = 1'b0;
        count_s = {COUNT_W{1'b0}};
        ovr_s   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      req_r   <= 1'b0;
      count_r <= {COUNT_W{1'b0}};
      ovr_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      req_r   <= req_s;
      count_r <= count_s;
      ovr_r   <= ovr_s;
    end
  end

  assign state      = state_r;
  assign step_req   = req_r;
  assign step_count = count_r;
  assign overrun    = ovr_r;

endmodule

// File: tb/tb_snake_step_scheduler.sv
// Scoreboard bench for snake_step_scheduler: directed scenarios plus random pulses,
// expected outputs come from a cycle-elapsed reference model of the game rules.
module tb_snake_step_scheduler;

  localparam int PW  = 41;
  localparam int MINP = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          collide = 1'b0;
  logic          step_ack = 1'b0;
  logic [PW-1:0] period = 41'd10;
  logic          step_req;
  logic [1:0]    state;
  logic [CW-1:0] step_count;
  logic          overrun;

  snake_step_scheduler #(.PERIOD_W(PW), .MIN_PERIOD(MINP), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .collide(collide),
    .period(period), .step_ack(step_ack), .step_req(step_req), .state(state),
    .step_count(step_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    st;
    logic          req;
    logic [CW-1:0] cnt;
    logic          ovr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   started = 1'b0;

  // Reference model: 0 idle, 1 run, 2 pause, 3 dead; elapsed = cycles run since last step boundary.
  int     m_state = 0;
  longint m_elapsed = 0;
  bit     m_req = 1'b0;
  int     m_cnt = 0;
  bit     m_ovr = 1'b0;
  longint per_next = 10;

  task automatic model_step();
    longint eff;
    bit     keep;
    exp_t   e;
    eff  = (longint'(period) < MINP) ? MINP : longint'(period);
    keep = m_req && !step_ack;
    if (rst) begin
      m_state = 0; m_elapsed = 0; m_req = 0; m_cnt = 0; m_ovr = 0;
    end else if (collide && (m_state == 1 || m_state == 2)) begin
      m_state = 3; m_req = 0; m_elapsed = 0;
    end else if (start && (m_state == 0 || m_state == 3)) begin
      m_state = 1; m_elapsed = 0; m_req = 0; m_cnt = 0; m_ovr = 0;
    end else if (pause && m_state == 1) begin
      m_state = 2; m_req = keep;
    end else if (pause && m_state == 2) begin
      m_state = 1; m_req = keep;
    end else if (m_state == 1) begin
      if (m_elapsed + 1 >= eff) begin
        m_elapsed = 0;
        if (keep) m_ovr = 1;
        else begin
          m_req = 1;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
      end else begin
        m_elapsed++;
        m_req = keep;
      end
    end else begin
      m_req = keep;
    end
    e.st = 2'(m_state); e.req = m_req; e.cnt = CW'(m_cnt); e.ovr = m_ovr;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit s, input bit p, input bit c, input bit a);
    @(negedge clk);
    rst = r; start = s; pause = p; collide = c; step_ack = a;
    period = PW'(per_next);
    started = 1'b1;
    model_step();
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Monitor: pops one expected record per clock and compares all outputs.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (started) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL queue_empty at %0t: got no expectation, expected one", $time);
      end else begin
        e = exp_q.pop_front();
        chk("state", int'(state), int'(e.st));
        chk("step_req", int'(step_req), int'(e.req));
        chk("step_count", int'(step_count), int'(e.cnt));
        chk("overrun", int'(overrun), int'(e.ovr));
      end
    end
  end

  initial begin
    int sel;
    // reset
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // basic stepping, ack one cycle after each request
    per_next = 10;
    cyc(0, 1, 0, 0, 0);
    repeat (40) cyc(0, 0, 0, 0, m_req);
    // overrun, then ack coinciding with expiry
    cyc(0, 1, 0, 0, 0);
    repeat (25) cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && m_elapsed != 9; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    // live period lowering and the floor
    per_next = 100;
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 200 && m_elapsed != 50; i++) cyc(0, 0, 0, 0, m_req);
    per_next = 10;
    repeat (25) cyc(0, 0, 0, 0, m_req);
    per_next = 0;
    repeat (12) cyc(0, 0, 0, 0, m_req);
    per_next = 2;
    repeat (12) cyc(0, 0, 0, 0, m_req);
    // pause at count 6 with a pending request, ack while paused, resume
    per_next = 10;
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 40 && !(m_req && m_elapsed == 6); i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (40) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    repeat (5) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (15) cyc(0, 0, 0, 0, m_req);
    // collide with a pending request, ignored pulses in DEAD, restart
    for (int i = 0; i < 40 && !m_req; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    repeat (15) cyc(0, 0, 0, 0, m_req);
    // reset mid-count with a request pending, then collide+pause together
    for (int i = 0; i < 40 && !(m_req && m_elapsed >= 3); i++) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    // step_count saturation
    per_next = 4;
    cyc(0, 1, 0, 0, 0);
    repeat (80) cyc(0, 0, 0, 0, m_req);
    // randomized pulses, acks and period changes
    repeat (3000) begin
      if ($urandom_range(0, 49) == 0) begin
        sel = $urandom_range(0, 5);
        case (sel)
          0: per_next = 0;
          1: per_next = 2;
          2: per_next = 4;
          3: per_next = 5;
          4: per_next = 7;
          default: per_next = 13;
        endcase
      end
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 29) == 0), ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 1) == 1));
    end
    // drain
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snake_step_scheduler.md
Name: snake_step_scheduler

Overview:
Sequences snake movement for the game core. Counts clk cycles against the period from the speed selector and issues one step request per period. Holds each request until the game-update logic acknowledges it. Runs the IDLE/RUN/PAUSE/DEAD game-flow FSM, so movement stops on pause or collision.

Parameters:
PERIOD_W, 41, width of the period input and the internal cycle counter
MIN_PERIOD, 1_000_000, floor on the effective period in clk cycles; a period of 0 or below this value is replaced by MIN_PERIOD
COUNT_W, 16, width of step_count

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse; begins or restarts a game
pause  input  1  one-cycle pulse; toggles RUN/PAUSE
collide  input  1  one-cycle pulse from collision detect; ends the game
period  input  PERIOD_W  cycles per step, from the speed selector; may change at any time
step_ack  input  1  game logic has consumed the current step
step_req  output  1  step pending; level, held until acknowledged
state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DEAD
step_count  output  COUNT_W  steps issued since start; saturating
overrun  output  1  sticky; a period expired while step_req was still pending

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, cycle counter cnt=0, step_req=0, step_count=0, overrun=0. Reset overrides every other input, including mid-handshake and mid-count.
- Effective period: p_eff = (period < MIN_PERIOD) ? MIN_PERIOD : period.
  - period is compared live every cycle; it is not latched.
- IDLE:
  - cnt held at 0.
  - start -> RUN; cnt, step_count and overrun are cleared on that edge.
- RUN:
  - cnt increments by 1 each cycle.
  - Expiry occurs when cnt >= p_eff-1. On expiry:
    - cnt <= 0.
    - If step_req==0: step_req <= 1 and step_count increments (holds at all-ones).
    - If step_req==1: no new request is issued, step_count is unchanged, overrun <= 1.
  - Consequence: the first step_req rises p_eff cycles after the start edge.
  - Using >= means a period lowered below the current cnt expires on the next cycle; a period raised takes effect without a spurious step.
- Handshake:
  - step_ack is only meaningful while step_req==1. When step_ack is sampled high, step_req <= 0 on that edge.
  - step_ack while step_req==0 is ignored.
  - If expiry and ack occur in the same cycle with step_req==1: the ack clears the old request and a new request is issued, so step_req stays 1. step_count increments and overrun is not set.
  - Handshake rules apply identically in RUN and PAUSE.
- PAUSE:
  - RUN + pause -> PAUSE. cnt is frozen and no expiry occurs.
  - A pending step_req stays high until acked.
  - pause in PAUSE -> RUN; cnt resumes from its frozen value, giving no phase loss.
- DEAD:
  - collide in RUN or PAUSE -> DEAD. step_req <= 0 immediately and any pending step is discarded. cnt <= 0.
  - step_count and overrun are held for the score display.
  - start in DEAD -> RUN with the same clears as IDLE->RUN.
- Priority within one cycle: rst > collide > start > pause.
  - start in RUN or PAUSE is ignored.
  - collide in IDLE or DEAD is ignored.
  - pause in IDLE or DEAD is ignored.
- Outputs are registered; no combinational path from any input to any output.

Test Plan:
- Basic stepping (MIN_PERIOD=4, period=10): rst, then start at cycle 0, ack 1 cycle after each req -> step_req rises at cycles 10, 20, 30; step_count=1, 2, 3; overrun=0.
- Overrun and simultaneous events (period=10): hold step_ack low for 25 cycles -> one step_req held high, step_count=1, overrun=1 at the cycle-20 expiry. Then ack exactly on the cycle-30 expiry -> step_req stays 1, step_count=2.
- Live period change and floor:
  - Period 100 lowered to 10 at cnt=50 -> expiry on the next cycle, then every 10 cycles.
  - period=0 or period=2 -> steps every 4 cycles.
- Pause/resume (period=10, pause at cnt=6): hold PAUSE 40 cycles -> no new step_req and cnt frozen at 6. Pending req cleared by ack while paused. After resume, next req 4 cycles later.
- Collide and restart:
  - Collide while step_req=1 -> state=DEAD, step_req=0 next cycle, step_count held.
  - pause and collide in DEAD ignored.
  - start -> RUN, step_count=0, overrun=0, first req after 10 cycles.
- Reset and priority:
  - rst asserted mid-count with step_req=1 -> all outputs at reset values on the next edge.
  - collide+pause in the same cycle in RUN -> DEAD.
  - step_count saturation with COUNT_W=4 -> holds at 15.
